// File: rtl/dog_streamer.sv
// Difference-of-Gaussian producer: forms three offset-coded DoG samples per accepted beat and
// streams one N*M frame per start/frame_ack handshake. Optional clamp: define DOG_CLAMP_EN.
module dog_streamer #(
  parameter int unsigned N      = 480,
  parameter int unsigned M      = 320,
  parameter int unsigned THRESH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  g0,
  input  logic [7:0]  g1,
  input  logic [7:0]  g2,
  input  logic [7:0]  g3,
  input  logic        frame_ack,
  output logic        data_valid,
  output logic [15:0] Diff1,
  output logic [15:0] Diff2,
  output logic [15:0] Diff3,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned Beats   = N * M;
  localparam logic [17:0] LastCnt = 18'(Beats - 1);

  // Frame must fit the 18-bit beat counter; THRESH beyond 256 would clamp everything.
  if (Beats == 0 || Beats > (1 << 18) || THRESH > 256) begin : g_bad_params
    $error("dog_streamer: illegal N, M or THRESH");
  end

  typedef enum logic [1:0] {StIdle, StStream, StWaitAck} state_e;

  state_e      state_q;
  logic [17:0] cnt_q;
  logic        data_valid_q;
  logic        frame_done_q;
  logic [8:0]  diff1_q, diff2_q, diff3_q;
  logic [8:0]  diff1_d, diff2_d, diff3_d;

  // Offset-coded difference hi - lo + 256; the true value lies in 1..511 so 9-bit wrap is exact.
  function automatic logic [8:0] dog(input logic [7:0] lo, input logic [7:0] hi);
    logic [8:0] d;
    logic [7:0] mag;
    d   = {1'b0, hi} - {1'b0, lo} + 9'd256;
    mag = (hi >= lo) ? (hi - lo) : (lo - hi);
`ifdef DOG_CLAMP_EN
    if ({24'd0, mag} < THRESH) begin
      d = 9'd256;
    end
`else
    mag = '0;
`endif
    return d;
  endfunction

  always_comb begin
    diff1_d = dog(g0, g1);
    diff2_d = dog(g1, g2);
    diff3_d = dog(g2, g3);
  end

  assign in_ready   = (state_q == StStream);
  assign busy       = (state_q != StIdle);
  assign data_valid = data_valid_q;
  assign frame_done = frame_done_q;
  assign Diff1      = {7'd0, diff1_q};
  assign Diff2      = {7'd0, diff2_q};
  assign Diff3      = {7'd0, diff3_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      diff1_q      <= '0;
      diff2_q      <= '0;
      diff3_q      <= '0;
    end else begin
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StStream;
            cnt_q   <= '0;
          end
        end
        StStream: begin
          // frame_ack is deliberately not looked at here, even on the last beat.
          if (in_valid) begin
            data_valid_q <= 1'b1;
            diff1_q      <= diff1_d;
            diff2_q      <= diff2_d;
            diff3_q      <= diff3_d;
            if (cnt_q == LastCnt) begin
              frame_done_q <= 1'b1;
              state_q      <= StWaitAck;
              cnt_q        <= '0;
            end else begin
              cnt_q <= cnt_q + 18'd1;
            end
          end
        end
        StWaitAck: begin
          if (frame_ack) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
